// File: rtl/sample_scheduler.sv
// Periodic sensor sampler with circular history buffer, graph read port and serial dump.
// rd_data/rd_valid 1 cycle after rd_addr; tx bytes held while tx_valid & !tx_ready; sns_req held until sns_ack.
module sample_scheduler #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int N_SAMPLES = 20,
    parameter int DATA_W    = 9,
    parameter int Y_MAX     = 299
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_sample,
    input  logic              btn_send,
    input  logic              btn_reset,
    input  logic [13:0]       period_ms,
    output logic              sns_req,
    input  logic              sns_ack,
    input  logic [DATA_W-1:0] sns_data,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              running,
    output logic              sending,
    output logic [4:0]        count
);

    localparam int TPM = CLK_HZ / 1000;
    localparam int TW  = (TPM > 1) ? $clog2(TPM) : 1;

    typedef enum logic [1:0] {IDLE, RUN, REQ, SEND} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q;
    logic [13:0]       ms_q;
    logic [4:0]        wr_ptr_q;
    logic [5:0]        cnt_q;
    logic [5:0]        tx_idx_q;
    logic              stop_q;
    logic [DATA_W-1:0] mem [N_SAMPLES];

    logic              tick_last, period_done, wr_en, tx_fire, tx_last, rd_hit;
    logic [13:0]       period_eff;
    logic [4:0]        oldest;
    logic [6:0]        tx_total;
    logic [DATA_W-1:0] sat_data, tx_sample;
    logic [15:0]       tx_wide;

    // Logical index -> physical slot, relative to the oldest stored sample.
    function automatic logic [4:0] phys(input logic [4:0] idx, input logic [4:0] base);
        logic [5:0] s;
        s = {1'b0, base} + {1'b0, idx};
        if (s >= 6'(N_SAMPLES))
            s = s - 6'(N_SAMPLES);
        return s[4:0];
    endfunction

    always_comb begin
        tick_last   = (tick_q == TW'(TPM - 1));
        period_eff  = (period_ms == 14'd0) ? 14'd1 : period_ms;
        // Compare with >= so a period lowered below the current ms count ends at the next ms tick.
        period_done = tick_last && (({1'b0, ms_q} + 15'd1) >= {1'b0, period_eff});
        wr_en       = (state_q == REQ) && sns_ack && !btn_reset;
        tx_fire     = (state_q == SEND) && tx_ready;
        tx_total    = {cnt_q, 1'b0};
        tx_last     = ({1'b0, tx_idx_q} == (tx_total - 7'd1));
        oldest      = (cnt_q < 6'(N_SAMPLES)) ? 5'd0 : wr_ptr_q;
        sat_data    = (sns_data > DATA_W'(Y_MAX)) ? DATA_W'(Y_MAX) : sns_data;
        rd_hit      = ({1'b0, rd_addr} < cnt_q);
        tx_sample   = mem[phys(tx_idx_q[5:1], oldest)];
        tx_wide     = 16'(tx_sample);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (btn_reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_sample)
                        state_d = RUN;
                    else if (btn_send && cnt_q != 6'd0)
                        state_d = SEND;
                end
                RUN: begin
                    if (btn_sample)
                        state_d = IDLE;
                    else if (period_done)
                        state_d = REQ;
                end
                REQ: begin
                    if (sns_ack)
                        state_d = (stop_q || btn_sample) ? IDLE : RUN;
                end
                SEND: begin
                    if (tx_fire && tx_last)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sns_req  = (state_q == REQ);
        running  = (state_q == RUN) || (state_q == REQ);
        sending  = (state_q == SEND);
        tx_valid = (state_q == SEND);
        tx_data  = 8'd0;
        if (state_q == SEND)
            tx_data = tx_idx_q[0] ? tx_wide[7:0] : tx_wide[15:8];
        count    = cnt_q[4:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q   <= '0;
            ms_q     <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            tx_idx_q <= '0;
            stop_q   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            // Timer only advances while staying in RUN, so every entry to RUN starts a full period.
            if (state_q != RUN || state_d != RUN) begin
                tick_q <= '0;
                ms_q   <= '0;
            end else if (tick_last) begin
                tick_q <= '0;
                ms_q   <= ms_q + 14'd1;
            end else begin
                tick_q <= tick_q + TW'(1);
            end

            stop_q <= (state_q == REQ) && (state_d == REQ) && (stop_q || btn_sample);

            if (btn_reset) begin
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else if (wr_en) begin
                wr_ptr_q <= (wr_ptr_q == 5'(N_SAMPLES - 1)) ? 5'd0 : wr_ptr_q + 5'd1;
                if (cnt_q != 6'(N_SAMPLES))
                    cnt_q <= cnt_q + 6'd1;
            end

            if (state_q != SEND)
                tx_idx_q <= '0;
            else if (tx_fire)
                tx_idx_q <= tx_idx_q + 6'd1;

            rd_valid <= rd_hit;
            rd_data  <= rd_hit ? mem[phys(rd_addr, oldest)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= sat_data;
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Randomized bench for sample_scheduler against a queue-based model of the sample history.
module tb_sample_scheduler;

    localparam int N  = 20;
    localparam int YM = 299;

    logic        clk = 1'b0;
    logic        rst, btn_sample, btn_send, btn_reset;
    logic [13:0] period_ms;
    logic        sns_req, sns_ack;
    logic [8:0]  sns_data;
    logic [4:0]  rd_addr;
    logic [8:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, running, sending;
    logic [4:0]  count;

    int n_checks = 0;
    int n_errors = 0;
    int model_q[$];

    always #5 clk = ~clk;

    sample_scheduler #(
        .CLK_HZ(1000), .N_SAMPLES(N), .DATA_W(9), .Y_MAX(YM)
    ) dut (
        .clk(clk), .rst(rst), .btn_sample(btn_sample), .btn_send(btn_send),
        .btn_reset(btn_reset), .period_ms(period_ms), .sns_req(sns_req),
        .sns_ack(sns_ack), .sns_data(sns_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .running(running),
        .sending(sending), .count(count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and drop every single-cycle pulse.
    task automatic step();
        @(negedge clk);
        btn_sample = 1'b0;
        btn_send   = 1'b0;
        btn_reset  = 1'b0;
        sns_ack    = 1'b0;
    endtask

    task automatic model_push(input int v);
        model_q.push_back((v > YM) ? YM : v);
        if (model_q.size() > N)
            void'(model_q.pop_front());
    endtask

    // Request must appear one full period (1 ms = 1 cycle here) after the start/ack edge.
    task automatic wait_req(input int per);
        int n = 0;
        int eff = (per == 0) ? 1 : per;
        do begin
            step();
            n++;
        end while (!sns_req && n < 200);
        check("req_latency", n, eff + 1);
    endtask

    task automatic give_ack(input int v, input int delay);
        repeat (delay) begin
            step();
            check("req_held", sns_req, 1);
        end
        sns_data = 9'(v);
        sns_ack  = 1'b1;
        model_push(v);
    endtask

    task automatic start_run(input int per);
        period_ms  = 14'(per);
        btn_sample = 1'b1;
    endtask

    task automatic stop_run();
        step();
        btn_sample = 1'b1;
        step();
        check("stopped", running, 0);
    endtask

    task automatic clear_all();
        btn_reset = 1'b1;
        model_q.delete();
        step();
    endtask

    task automatic check_buffer();
        check("count", count, model_q.size());
        for (int i = 0; i < N + 2; i++) begin
            rd_addr = 5'(i);
            step();
            check($sformatf("rd_valid[%0d]", i), rd_valid, (i < model_q.size()) ? 1 : 0);
            check($sformatf("rd_data[%0d]", i), rd_data, (i < model_q.size()) ? model_q[i] : 0);
        end
    endtask

    task automatic send_and_check();
        int exp_b[$];
        int got_b[$];
        int prev_stall = 0;
        int prev_data  = 0;
        int n = 0;
        int cnt_before = model_q.size();
        foreach (model_q[i]) begin
            exp_b.push_back(model_q[i] / 256);
            exp_b.push_back(model_q[i] % 256);
        end
        btn_send = 1'b1;
        step();
        check("sending", sending, 1);
        while (tx_valid && n < 2000) begin
            if (prev_stall != 0)
                check("tx_hold", tx_data, prev_data);
            tx_ready = 1'($urandom_range(0, 1));
            if (tx_ready)
                got_b.push_back(int'(tx_data));
            prev_stall = tx_ready ? 0 : 1;
            prev_data  = int'(tx_data);
            step();
            n++;
        end
        tx_ready = 1'b0;
        check("tx_nbytes", got_b.size(), exp_b.size());
        foreach (exp_b[i])
            check($sformatf("tx_byte[%0d]", i), (i < got_b.size()) ? got_b[i] : -1, exp_b[i]);
        check("send_done", sending, 0);
        check("count_kept", count, cnt_before);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int k, per;
        rst = 1'b1; btn_sample = 1'b0; btn_send = 1'b0; btn_reset = 1'b0;
        sns_ack = 1'b0; sns_data = '0; rd_addr = '0; tx_ready = 1'b0; period_ms = 14'd3;
        repeat (3) @(negedge clk);
        check("rst_req", sns_req, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_run", running, 0);
        check("rst_send", sending, 0);
        check("rst_count", count, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_rdd", rd_data, 0);
        check("rst_txd", tx_data, 0);
        rst = 1'b0;
        step();

        // First sample one period after start.
        start_run(3);
        wait_req(3);
        give_ack(42, 0);
        stop_run();
        check_buffer();

        // Overfill with 0..24, mixing period 0 and 2.
        clear_all();
        start_run(1);
        wait_req(1);
        for (int v = 0; v < 25; v++) begin
            give_ack(v, v % 3);
            if (v < 24) begin
                per = (v % 2 != 0) ? 0 : 2;
                period_ms = 14'(per);
                wait_req(per);
            end
        end
        stop_run();
        check_buffer();
        send_and_check();

        // Saturation at Y_MAX.
        clear_all();
        start_run(0);
        wait_req(0);
        give_ack(400, 1);
        period_ms = 14'd0;
        wait_req(0);
        give_ack(299, 0);
        wait_req(0);
        give_ack(300, 0);
        stop_run();
        check_buffer();

        // Empty buffer: send refused.
        clear_all();
        btn_send = 1'b1;
        step();
        check("send_empty", sending, 0);

        // Period lowered below the ms count; btn_send ignored while running.
        start_run(5);
        step();
        btn_send = 1'b1;
        step();
        check("send_in_run", sending, 0);
        check("still_run", running, 1);
        step();
        check("req_not_yet", sns_req, 0);
        period_ms = 14'd1;
        step();
        check("req_lowered", sns_req, 1);
        give_ack(123, 0);
        stop_run();
        check_buffer();

        // Three samples streamed with random back-pressure.
        clear_all();
        start_run(2);
        wait_req(2);
        give_ack(1, 0);
        wait_req(2);
        give_ack(256, 2);
        wait_req(2);
        give_ack(7, 1);
        stop_run();
        send_and_check();

        // Reset during REQ, late ack must be ignored.
        start_run(2);
        wait_req(2);
        btn_reset = 1'b1;
        model_q.delete();
        step();
        check("rstreq_req", sns_req, 0);
        check("rstreq_count", count, 0);
        step();
        sns_data = 9'd77;
        sns_ack  = 1'b1;
        step();
        step();
        check("rstreq_run", running, 0);
        check_buffer();

        // Stop pressed during REQ: sample kept, then idle.
        start_run(1);
        wait_req(1);
        btn_sample = 1'b1;
        step();
        check("stopreq_held", sns_req, 1);
        sns_data = 9'd55;
        sns_ack  = 1'b1;
        model_push(55);
        step();
        check("stopreq_run", running, 0);
        check("stopreq_req", sns_req, 0);
        step();
        check("stopreq_idle", running, 0);
        check_buffer();

        // Randomized fills, each dumped afterwards.
        repeat (4) begin
            clear_all();
            k   = $urandom_range(1, 28);
            per = $urandom_range(0, 3);
            start_run(per);
            wait_req(per);
            for (int j = 0; j < k; j++) begin
                give_ack($urandom_range(0, 511), $urandom_range(0, 2));
                if (j < k - 1) begin
                    per = $urandom_range(0, 3);
                    period_ms = 14'(per);
                    wait_req(per);
                end
            end
            stop_run();
            check_buffer();
            send_and_check();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
